if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage of the five-stage MIPS pipeline. Each cycle it keeps one sequential instruction address in flight to instruction memory and buffers the returned words. It delivers `{pc, inst}` pairs to the IF/ID register.
- ID's `branch_flag_o` / `branch_target_address_o` redirect it, with MIPS branch-delay-slot semantics preserved.
- The pipeline stall signal back-pressures it.

## Interface
Parameters: none. Reset PC is the `InitialPc` macro (32'h0000_0000); buses use `InstAddrBus` / `InstBus` (32 bits).
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- stall_i  in  1  IF/ID cannot accept this cycle (hold output)
- branch_flag_i  in  1  redirect request from ID; honoured only when stall_i=0
- branch_target_address_i  in  32  redirect target
- inst_req_o  out  1  memory request valid
- inst_addr_o  out  32  request address; stable while inst_req_o=1 and not granted
- inst_gnt_i  in  1  memory accepts request this cycle
- inst_rvalid_i  in  1  read data valid; earliest one cycle after grant
- inst_rdata_i  in  32  read data
- if_valid_o  out  1  output holds an instruction
- if_pc_o  out  32  PC of delivered instruction
- if_inst_o  out  32  delivered instruction
- if_adel_o  out  1  fetch address error (see Configuration)

## Operation
- Registers:
  - next_pc: next address to issue
  - req_addr: address of the current request
  - out buffer {valid, pc, inst}
  - one-entry skid buffer {valid, pc, inst}
  - discard flag
- FSM states IDLE, REQ, WAIT, HOLD:
  - IDLE: entered on reset; goes to REQ next cycle.
  - REQ: inst_req_o=1, inst_addr_o=req_addr. On inst_gnt_i go to WAIT.
  - WAIT: on inst_rvalid_i:
    - discard=1: drop the data, clear discard.
    - discard=0: write {req_addr, rdata} into out if out is empty or consumed this cycle, otherwise into skid.
    - Next state is REQ if the skid is empty after the update, else HOLD.
  - HOLD: wait until the skid drains, then go to REQ.
- Issue: on every entry to REQ, req_addr:=next_pc and next_pc:=next_pc+4 (32-bit wrap, no carry out).
- At most one request is outstanding, so out + skid can never overflow and no word is ever dropped.
- Consume: out is consumed in a cycle with out.valid=1 and stall_i=0.
  - On consume, skid moves to out, else a new response moves to out, else out.valid:=0.
  - Delivery order is strictly program order.
- Redirect (branch_flag_i=1, stall_i=0). The branch is in ID; the delay slot is the next instruction after it.
  - out.valid=1: the out word is the delay slot and is consumed this cycle. Flush the skid. Set discard:=1 if in REQ (granted later) or WAIT. next_pc:=target.
  - out.valid=0: the current request (REQ or WAIT) is the delay slot and is kept. Only next_pc:=target.
  - A REQ that is already presenting an address keeps that address until granted.
- inst_rvalid_i outside WAIT is ignored; this covers stale responses after reset.

## Timing
- Reset values:
  - inst_req_o=0, inst_addr_o=InitialPc
  - if_valid_o=0, if_pc_o=InitialPc, if_inst_o=ZeroWord, if_adel_o=0
  - next_pc=InitialPc, discard=0, skid empty
- First request is asserted the cycle after rst falls.
- inst_req_o and inst_addr_o are decoded from state and req_addr; if_* outputs are registered.
- rvalid in cycle t gives if_valid_o=1 in cycle t+1.
- With single-cycle memory (gnt in the same cycle as req, rvalid the next cycle), throughput is one instruction per 2 cycles.
- Redirect latency: the first target request is issued no earlier than the cycle after the delay-slot request is granted.
- Simultaneous branch and rvalid in WAIT: the redirect rule applies first. If out.valid=1 the arriving word is dropped; otherwise it is kept as the delay slot.
- rst asserted mid-request: all state clears immediately and the outstanding response is ignored.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect target with addr[1:0]≠0 is not fetched.
  - Once the delay slot is delivered, the block places {target, ZeroWord} in out with if_adel_o=1 and enters IDLE-halt (no requests).
  - It leaves halt only on the next redirect or on reset.
- Not defined: target[1:0] is forced to 2'b00 and if_adel_o is tied 0.

## Test plan
- Reset, single-cycle memory returning rdata=addr: if_pc_o/if_inst_o = 0x0, 0x4, 0x8, each valid one cycle, spaced 2 cycles apart.
- stall_i=1 for 6 cycles with words 0x0 and 0x4 returned: out holds 0x0, skid holds 0x4, inst_req_o=0 in HOLD. After release, 0x0 then 0x4 are delivered in order and 0x8 is requested next.
- Branch to 0x100 with out=0x8 valid and request 0xC in WAIT: 0x8 is consumed, the 0xC response is dropped, and the next if_pc_o is 0x100.
- Branch to 0x100 with out empty and 0x8 in WAIT: 0x8 is delivered, then 0x100 and 0x104.
- rst pulsed while in WAIT, with rvalid arriving 1 cycle after rst falls: the response is ignored, all outputs return to reset values, and the first request is to InitialPc.
- FETCH_ALIGN_CHECK_EN set, branch to 0x102: the delay slot is delivered, then if_pc_o=0x102, if_inst_o=0, if_adel_o=1, and inst_req_o stays 0 until a branch to 0x200.

Source files
------------

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage of the five-stage MIPS pipeline.
// Keeps at most one sequential fetch in flight to instruction memory, buffers
// returned words in an output register plus a one-entry skid buffer, and hands
// {pc, inst} pairs to IF/ID in program order. Branch redirects from ID keep
// MIPS delay-slot semantics: the instruction after the branch is always
// delivered, anything fetched beyond it is dropped.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   : a misaligned redirect target is not fetched; after the delay
//               slot the stage emits {target, 0} with if_adel_o=1 and halts
//               (no requests) until the next redirect or reset.
//   undefined : target[1:0] is forced to 2'b00 and if_adel_o is tied low.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   stall_i                      IF/ID cannot accept this cycle
//   branch_flag_i                redirect request (ignored while stalled)
//   branch_target_address_i      redirect target
//   inst_req_o, inst_addr_o      memory request and its address
//   inst_gnt_i                   memory accepts the request this cycle
//   inst_rvalid_i, inst_rdata_i  read response
//   if_valid_o, if_pc_o,
//   if_inst_o, if_adel_o         delivered instruction to IF/ID

`ifndef InitialPc
`define InitialPc 32'h0000_0000
`endif
`ifndef ZeroWord
`define ZeroWord 32'h0000_0000
`endif

module if_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_gnt_i,
  input  logic        inst_rvalid_i,
  input  logic [31:0] inst_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_adel_o
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam logic [ADDR_W-1:0] INIT_PC   = `InitialPc;
  localparam logic [DATA_W-1:0] ZERO_WORD = `ZeroWord;
  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  localparam entry_t ENTRY_RST = '{valid: 1'b0, pc: INIT_PC, inst: ZERO_WORD};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] next_pc_q, next_pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  entry_t            out_q, out_d;
  entry_t            skid_q, skid_d;
  logic              discard_q, discard_d;

  logic              consume;
  logic              redirect;
  logic              flush;
  logic              rsp;
  logic              rsp_keep;
  logic              go_req;
  logic [ADDR_W-1:0] target;
  entry_t            rsp_entry;

`ifdef FETCH_ALIGN_CHECK_EN
  logic              misaligned;
  logic              halt_q, halt_d;
  logic              adel_pend_q, adel_pend_d;
  logic [ADDR_W-1:0] adel_addr_q, adel_addr_d;
  logic              out_adel_q, out_adel_d;

  assign target     = branch_target_address_i;
  assign misaligned = |branch_target_address_i[1:0];
`else
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(3);

  assign target = branch_target_address_i & ~ALIGN_MASK;
`endif

  // Handshake qualifiers shared by the datapath and the FSM.
  assign consume   = out_q.valid & ~stall_i;
  assign redirect  = branch_flag_i & ~stall_i;
  // With a word in out, that word is the delay slot: anything younger is stale.
  assign flush     = redirect & out_q.valid;
  assign rsp       = (state_q == S_WAIT) & inst_rvalid_i;
  assign rsp_keep  = rsp & ~discard_q & ~flush;
  assign rsp_entry = '{valid: 1'b1, pc: req_addr_q, inst: inst_rdata_i};

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      next_pc_q   <= INIT_PC;
      req_addr_q  <= INIT_PC;
      out_q       <= ENTRY_RST;
      skid_q      <= ENTRY_RST;
      discard_q   <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      halt_q      <= 1'b0;
      adel_pend_q <= 1'b0;
      adel_addr_q <= INIT_PC;
      out_adel_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      next_pc_q   <= next_pc_d;
      req_addr_q  <= req_addr_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      discard_q   <= discard_d;
`ifdef FETCH_ALIGN_CHECK_EN
      halt_q      <= halt_d;
      adel_pend_q <= adel_pend_d;
      adel_addr_q <= adel_addr_d;
      out_adel_q  <= out_adel_d;
`endif
    end
  end

  // Next-state, buffer and address update logic.
  always_comb begin
    state_d     = state_q;
    next_pc_d   = next_pc_q;
    req_addr_d  = req_addr_q;
    out_d       = out_q;
    skid_d      = skid_q;
    discard_d   = discard_q;
    go_req      = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    halt_d      = halt_q;
    adel_pend_d = adel_pend_q;
    adel_addr_d = adel_addr_q;
    out_adel_d  = out_adel_q & ~consume;
`endif

    // Redirect: retarget the next issue; the request in flight is untouched.
    if (redirect) begin
`ifdef FETCH_ALIGN_CHECK_EN
      adel_pend_d = misaligned;
      if (misaligned) begin
        adel_addr_d = branch_target_address_i;
      end else begin
        next_pc_d = target;
      end
`else
      next_pc_d = target;
`endif
    end

    // A response always retires the discard; an outstanding or not-yet-granted
    // fetch behind a consumed delay slot must be thrown away when it returns.
    if (rsp) begin
      discard_d = 1'b0;
    end
    if (flush && ((state_q == S_REQ) || ((state_q == S_WAIT) && !inst_rvalid_i))) begin
      discard_d = 1'b1;
    end

    // Output / skid buffers, strictly in program order.
    if (flush) begin
      skid_d.valid = 1'b0;
    end
    if (consume) begin
      if (skid_q.valid && !flush) begin
        out_d        = skid_q;
        skid_d.valid = 1'b0;
      end else if (rsp_keep) begin
        out_d = rsp_entry;
      end else begin
        out_d.valid = 1'b0;
      end
    end else if (rsp_keep) begin
      if (!out_q.valid) begin
        out_d = rsp_entry;
      end else begin
        skid_d = rsp_entry;
      end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Halted with an address error pending: emit it once out is free.
    if ((state_q == S_IDLE) && halt_q && adel_pend_q && !redirect &&
        (!out_q.valid || consume)) begin
      out_d       = '{valid: 1'b1, pc: adel_addr_q, inst: ZERO_WORD};
      out_adel_d  = 1'b1;
      adel_pend_d = 1'b0;
    end
`endif

    unique case (state_q)
      S_IDLE: begin
`ifdef FETCH_ALIGN_CHECK_EN
        go_req = !halt_q || redirect;
`else
        go_req = 1'b1;
`endif
      end
      S_REQ: begin
        if (inst_gnt_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rsp) begin
          if (skid_d.valid) begin
            state_d = S_HOLD;
          end else begin
            go_req = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (!skid_d.valid) begin
          go_req = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every entry into REQ issues next_pc (already retargeted if redirecting).
    if (go_req) begin
`ifdef FETCH_ALIGN_CHECK_EN
      if (adel_pend_d) begin
        state_d = S_IDLE;
        halt_d  = 1'b1;
      end else begin
        state_d    = S_REQ;
        halt_d     = 1'b0;
        req_addr_d = next_pc_d;
        next_pc_d  = next_pc_d + PC_STEP;
      end
`else
      state_d    = S_REQ;
      req_addr_d = next_pc_d;
      next_pc_d  = next_pc_d + PC_STEP;
`endif
    end
  end

  assign inst_req_o  = (state_q == S_REQ);
  assign inst_addr_o = req_addr_q;
  assign if_valid_o  = out_q.valid;
  assign if_pc_o     = out_q.pc;
  assign if_inst_o   = out_q.inst;
`ifdef FETCH_ALIGN_CHECK_EN
  assign if_adel_o   = out_adel_q;
`else
  assign if_adel_o   = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed, table-driven bench for if_fetch.
// The memory model grants in the request cycle and answers one cycle later
// with rdata equal to the address; 'hold' delays the answer, 'nogt' withholds
// the grant. Inputs change on the falling edge and outputs are compared 1 ns
// later, so each row sees the state left by the previous rising edge.

module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br;
  logic [31:0] tgt;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        adel;

  logic        hold;
  logic        nogt;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        hold;
    logic        nogt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vecs[$];

  if_fetch dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall_i                 (stall),
    .branch_flag_i           (br),
    .branch_target_address_i (tgt),
    .inst_req_o              (req),
    .inst_addr_o             (addr),
    .inst_gnt_i              (gnt),
    .inst_rvalid_i           (rvalid),
    .inst_rdata_i            (rdata),
    .if_valid_o              (valid),
    .if_pc_o                 (pc),
    .if_inst_o               (inst),
    .if_adel_o               (adel)
  );

  always #5 clk = ~clk;

  // Single-outstanding memory: one-cycle response, data = address.
  assign gnt    = req & ~nogt;
  assign rvalid = pend & ~hold;
  assign rdata  = pend_addr;

  always @(posedge clk) begin
    if (req && gnt) begin
      pend      <= 1'b1;
      pend_addr <= addr;
    end else if (rvalid) begin
      pend <= 1'b0;
    end
  end

  task automatic add(input logic r, input logic s, input logic b, input logic [31:0] t,
                     input logic h, input logic g, input logic e_req, input logic [31:0] e_addr,
                     input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_inst);
    vec_t v;
    v.rst = r; v.stall = s; v.br = b; v.tgt = t; v.hold = h; v.nogt = g;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc; v.e_inst = e_inst;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] t,
                       input logic h, input logic g);
    @(negedge clk);
    rst = r; stall = s; br = b; tgt = t; hold = h; nogt = g;
    #1;
  endtask

  // pc/inst are compared when a word is expected or when full reset values are.
  task automatic check(input string name, input logic e_req, input logic [31:0] e_addr,
                       input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_inst,
                       input logic e_adel, input logic full);
    logic ok;
    checks++;
    ok = (req === e_req) && (addr === e_addr) && (valid === e_valid) && (adel === e_adel);
    if (e_valid || full) begin
      ok = ok && (pc === e_pc) && (inst === e_inst);
    end
    if (!ok) begin
      errors++;
      $display("FAIL %s: got req=%0b addr=%h valid=%0b pc=%h inst=%h adel=%0b, want req=%0b addr=%h valid=%0b pc=%h inst=%h adel=%0b",
               name, req, addr, valid, pc, inst, adel, e_req, e_addr, e_valid, e_pc, e_inst, e_adel);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; br = 1'b0; tgt = 32'h0; hold = 1'b1; nogt = 1'b0;

    //   rst stl br tgt          hld ngt | req addr         vld pc           inst
    // reset, then single-cycle memory: one word every 2 cycles
    add(1, 0, 0, 32'h0,        1, 0,   0, 32'h0,        0, 32'h0,        32'h0);
    add(1, 0, 0, 32'h0,        0, 0,   0, 32'h0,        0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,        0, 0,   0, 32'h0,        0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,        0, 0,   1, 32'h0,        0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,        0, 0,   0, 32'h0,        0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,        0, 0,   1, 32'h4,        1, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,        0, 0,   0, 32'h4,        0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,        0, 0,   1, 32'h8,        1, 32'h4,        32'h4);
    add(0, 0, 0, 32'h0,        0, 0,   0, 32'h8,        0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,        0, 0,   1, 32'hC,        1, 32'h8,        32'h8);
    // reset while 0xC is outstanding, then 6-cycle stall fills out + skid
    add(1, 0, 0, 32'h0,        0, 0,   0, 32'h0,        0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,        0, 0,   0, 32'h0,        0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,        0, 0,   1, 32'h0,        0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,        0, 0,   0, 32'h0,        0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,        0, 0,   1, 32'h4,        1, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,        0, 0,   0, 32'h4,        1, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,        0, 0,   0, 32'h4,        1, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,        0, 0,   0, 32'h4,        1, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,        0, 0,   1, 32'h8,        1, 32'h4,        32'h4);
    add(0, 0, 0, 32'h0,        0, 0,   0, 32'h8,        0, 32'h0,        32'h0);
    // branch with out=0x8 valid, 0xC in WAIT: 0xC dropped, then 0x100
    add(0, 1, 0, 32'h0,        0, 0,   1, 32'hC,        1, 32'h8,        32'h8);
    add(0, 0, 1, 32'h100,      1, 0,   0, 32'hC,        1, 32'h8,        32'h8);
    add(0, 0, 0, 32'h0,        0, 0,   0, 32'hC,        0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,        0, 0,   1, 32'h100,      0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,        0, 0,   0, 32'h100,      0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,        0, 0,   1, 32'h104,      1, 32'h100,      32'h100);
    // branch with out empty, 0x104 in WAIT: 0x104 kept as delay slot
    add(0, 0, 1, 32'h200,      1, 0,   0, 32'h104,      0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,        0, 0,   0, 32'h104,      0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,        0, 0,   1, 32'h200,      1, 32'h104,      32'h104);
    add(0, 0, 0, 32'h0,        0, 0,   0, 32'h200,      0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,        0, 0,   1, 32'h204,      1, 32'h200,      32'h200);
    add(0, 0, 0, 32'h0,        0, 0,   0, 32'h204,      0, 32'h0,        32'h0);
    // branch together with rvalid: dropped when out valid, kept when out empty
    add(0, 1, 0, 32'h0,        0, 0,   1, 32'h208,      1, 32'h204,      32'h204);
    add(0, 0, 1, 32'h300,      0, 0,   0, 32'h208,      1, 32'h204,      32'h204);
    add(0, 0, 0, 32'h0,        0, 0,   1, 32'h300,      0, 32'h0,        32'h0);
    add(0, 0, 1, 32'h400,      0, 0,   0, 32'h300,      0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,        0, 0,   1, 32'h400,      1, 32'h300,      32'h300);
    add(0, 0, 0, 32'h0,        0, 0,   0, 32'h400,      0, 32'h0,        32'h0);
    // branch in REQ granted the same cycle: that fetch is discarded
    add(0, 0, 1, 32'h500,      0, 0,   1, 32'h404,      1, 32'h400,      32'h400);
    add(0, 0, 0, 32'h0,        0, 0,   0, 32'h404,      0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,        0, 0,   1, 32'h500,      0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,        0, 0,   0, 32'h500,      0, 32'h0,        32'h0);
    // ungranted REQ keeps its address across a redirect, then is discarded
    add(0, 1, 0, 32'h0,        0, 1,   1, 32'h504,      1, 32'h500,      32'h500);
    add(0, 0, 1, 32'h600,      0, 1,   1, 32'h504,      1, 32'h500,      32'h500);
    add(0, 0, 0, 32'h0,        0, 0,   1, 32'h504,      0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,        0, 0,   0, 32'h504,      0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,        0, 0,   1, 32'h600,      0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,        0, 0,   0, 32'h600,      0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,        0, 0,   1, 32'h604,      1, 32'h600,      32'h600);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].hold, vecs[i].nogt);
      check($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
            vecs[i].e_pc, vecs[i].e_inst, 1'b0, vecs[i].rst);
    end

    // Reset while 0x604 is in WAIT; the stale answer shows up in the REQ cycle.
    drive(1, 0, 0, 32'h0, 1, 0);
    check("rst_mid_wait", 0, 32'h0, 0, 32'h0, 32'h0, 0, 1);
    drive(0, 0, 0, 32'h0, 1, 0);
    check("rst_idle", 0, 32'h0, 0, 32'h0, 32'h0, 0, 1);
    drive(0, 0, 0, 32'h0, 0, 0);
    check("rst_stale_rvalid", 1, 32'h0, 0, 32'h0, 32'h0, 0, 1);
    drive(0, 0, 0, 32'h0, 0, 0);
    check("rst_first_wait", 0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 0);
    check("rst_first_word", 1, 32'h4, 1, 32'h0, 32'h0, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 0);
    check("rst_second_wait", 0, 32'h4, 0, 32'h0, 32'h0, 0, 0);

    // Misaligned branch target 0x102 with delay slot 0x4 in out.
    drive(0, 0, 1, 32'h102, 0, 0);
    check("mis_branch", 1, 32'h8, 1, 32'h4, 32'h4, 0, 0);
`ifdef FETCH_ALIGN_CHECK_EN
    drive(0, 0, 0, 32'h0, 0, 0);
    check("adel_drop", 0, 32'h8, 0, 32'h0, 32'h0, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 0);
    check("adel_halt", 0, 32'h8, 0, 32'h0, 32'h0, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 0);
    check("adel_word", 0, 32'h8, 1, 32'h102, 32'h0, 1, 0);
    drive(0, 0, 0, 32'h0, 0, 0);
    check("adel_halted", 0, 32'h8, 0, 32'h0, 32'h0, 0, 0);
    drive(0, 0, 1, 32'h200, 0, 0);
    check("adel_still_halted", 0, 32'h8, 0, 32'h0, 32'h0, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 0);
    check("adel_resume_req", 1, 32'h200, 0, 32'h0, 32'h0, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 0);
    check("adel_resume_wait", 0, 32'h200, 0, 32'h0, 32'h0, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 0);
    check("adel_resume_word", 1, 32'h204, 1, 32'h200, 32'h200, 0, 0);
`else
    drive(0, 0, 0, 32'h0, 0, 0);
    check("mis_drop", 0, 32'h8, 0, 32'h0, 32'h0, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 0);
    check("mis_forced_req", 1, 32'h100, 0, 32'h0, 32'h0, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 0);
    check("mis_forced_wait", 0, 32'h100, 0, 32'h0, 32'h0, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 0);
    check("mis_forced_word", 1, 32'h104, 1, 32'h100, 32'h100, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
